// File: rtl/ex_stage.sv
// ex_stage: MIPS-style execute stage with an EX/MEM pipeline latch and an
// iterative (one bit per cycle) multiply/divide unit that owns HI/LO.
// While a multiply/divide is in flight the stage raises Stall and pushes
// bubbles into the EX/MEM latch; the held instruction commits once on DONE.
module ex_stage #(
    parameter int MD_ITERS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ReadData1,
    input  logic [31:0] ReadData2,
    input  logic [31:0] SignExtImm,
    input  logic [31:0] PCPlus4,
    input  logic [4:0]  Rt,
    input  logic [4:0]  Rd,
    input  logic [5:0]  Funct,
    input  logic [1:0]  ALUOp,
    input  logic        ALUSrc,
    input  logic        RegDst,
    input  logic [1:0]  WBControl_in,
    input  logic        MemWrite_in,
    input  logic        MemRead_in,
    input  logic        Branch_in,
    output logic [31:0] ALUResult_out,
    output logic [31:0] WriteData_out,
    output logic [31:0] BranchTarget_out,
    output logic [4:0]  WriteReg_out,
    output logic [1:0]  WBControl_out,
    output logic        MemWrite_out,
    output logic        MemRead_out,
    output logic        Branch_out,
    output logic        Zero_out,
    output logic        Stall
);

    localparam int CNT_W = $clog2(MD_ITERS);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_ITERS - 1);

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_MFHI = 6'b010000;
    localparam logic [5:0] F_MFLO = 6'b010010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Two's-complement magnitude of v when it is a signed operand.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

    // One shift-add multiply step. w = {partial product high, multiplier / product low}.
    function automatic logic [63:0] mul_step(input logic [63:0] w, input logic [31:0] m);
        logic [32:0] sum;
        sum = {1'b0, w[63:32]} + (w[0] ? {1'b0, m} : 33'd0);
        return {sum, w[31:1]};
    endfunction

    // One restoring-divide step. w = {partial remainder, dividend / quotient}.
    // The partial remainder is always below the divisor, so the trial
    // difference fits in 33 bits; a zero divisor is patched up at commit.
    function automatic logic [63:0] div_step(input logic [63:0] w, input logic [31:0] d);
        logic [32:0] sh;
        logic [32:0] trial;
        sh    = w[63:31];
        trial = sh - {1'b0, d};
        if (trial[32]) begin
            return {sh[31:0], w[30:0], 1'b0};
        end
        return {trial[31:0], w[30:0], 1'b1};
    endfunction

    // Apply result signs and the divide-by-zero convention; returns {HI, LO}.
    function automatic logic [63:0] md_result(input logic [63:0] w, input logic is_div,
                                              input logic neg, input logic rneg,
                                              input logic dvz, input logic [31:0] dvd);
        logic [31:0] q;
        logic [31:0] r;
        if (!is_div) begin
            return neg ? (~w + 64'd1) : w;
        end
        if (dvz) begin
            return {dvd, 32'hFFFF_FFFF};
        end
        q = neg  ? (~w[31:0]  + 32'd1) : w[31:0];
        r = rneg ? (~w[63:32] + 32'd1) : w[63:32];
        return {r, q};
    endfunction

    // Control state
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;

    // Multiply/divide working state (meaningful only while BUSY)
    logic [63:0]       work_q, work_d;
    logic [31:0]       mcand_q, mcand_d;
    logic [31:0]       dvd_q, dvd_d;
    logic              is_div_q, is_div_d;
    logic              neg_q, neg_d;
    logic              rneg_q, rneg_d;
    logic              dvz_q, dvz_d;

    // EX/MEM latch
    logic [31:0]       alu_result_q, alu_result_d;
    logic [31:0]       write_data_q, write_data_d;
    logic [31:0]       branch_target_q, branch_target_d;
    logic [4:0]        write_reg_q, write_reg_d;
    logic [1:0]        wb_ctrl_q, wb_ctrl_d;
    logic              mem_write_q, mem_write_d;
    logic              mem_read_q, mem_read_d;
    logic              branch_q, branch_d;
    logic              zero_q, zero_d;

    logic [31:0]        op_b;
    logic signed [31:0] op_a_s;
    logic signed [31:0] op_b_s;
    logic [31:0]        alu_res;
    logic               is_muldiv;
    logic               md_sgn;
    logic               stall;
    logic               start;
    logic [63:0]        w_step;

    assign op_b      = ALUSrc ? SignExtImm : ReadData2;
    assign op_a_s    = ReadData1;
    assign op_b_s    = op_b;
    assign is_muldiv = (ALUOp == 2'b10) && (Funct[5:2] == 4'b0110);
    assign md_sgn    = ~Funct[0];
    assign Stall     = stall;

    // ALU operation decode and evaluation; mfhi/mflo read committed HI/LO.
    always_comb begin
        alu_res = '0;
        case (ALUOp)
            2'b00: alu_res = ReadData1 + op_b;
            2'b01: alu_res = ReadData1 - op_b;
            2'b10: begin
                case (Funct)
                    F_ADD:   alu_res = ReadData1 + op_b;
                    F_SUB:   alu_res = ReadData1 - op_b;
                    F_AND:   alu_res = ReadData1 & op_b;
                    F_OR:    alu_res = ReadData1 | op_b;
                    F_NOR:   alu_res = ~(ReadData1 | op_b);
                    F_SLT:   alu_res = {31'd0, (op_a_s < op_b_s)};
                    F_MFHI:  alu_res = hi_q;
                    F_MFLO:  alu_res = lo_q;
                    default: alu_res = '0;
                endcase
            end
            default: alu_res = '0;
        endcase
    end

    // Multiply/divide sequencer: next state, stall and start strobe.
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        start   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (is_muldiv) begin
                    stall   = 1'b1;
                    start   = 1'b1;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                stall = 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Multiply/divide datapath: operand capture on start, one step per BUSY cycle,
    // HI/LO commit on the final step.
    always_comb begin
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        work_d   = work_q;
        mcand_d  = mcand_q;
        dvd_d    = dvd_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dvz_d    = dvz_q;
        w_step   = is_div_q ? div_step(work_q, mcand_q) : mul_step(work_q, mcand_q);
        if (start) begin
            cnt_d    = CNT_LOAD;
            is_div_d = Funct[1];
            neg_d    = md_sgn & (ReadData1[31] ^ ReadData2[31]);
            rneg_d   = md_sgn & ReadData1[31];
            dvz_d    = (ReadData2 == 32'd0);
            dvd_d    = ReadData1;
            mcand_d  = mag32(ReadData2, md_sgn);
            work_d   = {32'd0, mag32(ReadData1, md_sgn)};
        end else if (state_q == S_BUSY) begin
            work_d = w_step;
            cnt_d  = cnt_q - CNT_W'(1);
            if (cnt_q == '0) begin
                {hi_d, lo_d} = md_result(w_step, is_div_q, neg_q, rneg_q, dvz_q, dvd_q);
            end
        end
    end

    // Architectural HI/LO and iteration counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end

    // Working registers; only read after a start has loaded them.
    always_ff @(posedge clk) begin
        work_q   <= work_d;
        mcand_q  <= mcand_d;
        dvd_q    <= dvd_d;
        is_div_q <= is_div_d;
        neg_q    <= neg_d;
        rneg_q   <= rneg_d;
        dvz_q    <= dvz_d;
    end

    // EX/MEM latch inputs: this cycle's results, control squashed to a bubble on stall.
    always_comb begin
        alu_result_d    = alu_res;
        zero_d          = (alu_res == 32'd0);
        write_data_d    = ReadData2;
        branch_target_d = PCPlus4 + {SignExtImm[29:0], 2'b00};
        write_reg_d     = RegDst ? Rd : Rt;
        wb_ctrl_d       = WBControl_in;
        mem_write_d     = MemWrite_in;
        mem_read_d      = MemRead_in;
        branch_d        = Branch_in;
        if (stall) begin
            wb_ctrl_d   = 2'b00;
            mem_write_d = 1'b0;
            mem_read_d  = 1'b0;
            branch_d    = 1'b0;
        end
    end

    // EX/MEM latch register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_result_q    <= '0;
            write_data_q    <= '0;
            branch_target_q <= '0;
            write_reg_q     <= '0;
            wb_ctrl_q       <= '0;
            mem_write_q     <= 1'b0;
            mem_read_q      <= 1'b0;
            branch_q        <= 1'b0;
            zero_q          <= 1'b0;
        end else begin
            alu_result_q    <= alu_result_d;
            write_data_q    <= write_data_d;
            branch_target_q <= branch_target_d;
            write_reg_q     <= write_reg_d;
            wb_ctrl_q       <= wb_ctrl_d;
            mem_write_q     <= mem_write_d;
            mem_read_q      <= mem_read_d;
            branch_q        <= branch_d;
            zero_q          <= zero_d;
        end
    end

    assign ALUResult_out    = alu_result_q;
    assign WriteData_out    = write_data_q;
    assign BranchTarget_out = branch_target_q;
    assign WriteReg_out     = write_reg_q;
    assign WBControl_out    = wb_ctrl_q;
    assign MemWrite_out     = mem_write_q;
    assign MemRead_out      = mem_read_q;
    assign Branch_out       = branch_q;
    assign Zero_out         = zero_q;

endmodule

// File: tb/tb_ex_stage.sv
// Testbench for ex_stage: directed vectors plus randomized ALU and
// multiply/divide traffic, checked against a plain-arithmetic reference.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] rd1, rd2, imm, pc4;
    logic [4:0]  rt, rd;
    logic [5:0]  funct;
    logic [1:0]  aluop, wbc_in;
    logic        alusrc, regdst, mw_in, mr_in, br_in;
    logic [31:0] alu_out, wd_out, bt_out;
    logic [4:0]  wr_out;
    logic [1:0]  wbc_out;
    logic        mw_out, mr_out, br_out, zero_out, stall;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25;
    localparam logic [5:0] F_NOR = 6'h27, F_SLT = 6'h2a, F_MFHI = 6'h10, F_MFLO = 6'h12;
    localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1a, F_DIVU = 6'h1b;

    always #5 clk = ~clk;

    ex_stage #(.MD_ITERS(32)) dut (
        .clk(clk), .reset(reset),
        .ReadData1(rd1), .ReadData2(rd2), .SignExtImm(imm), .PCPlus4(pc4),
        .Rt(rt), .Rd(rd), .Funct(funct), .ALUOp(aluop), .ALUSrc(alusrc), .RegDst(regdst),
        .WBControl_in(wbc_in), .MemWrite_in(mw_in), .MemRead_in(mr_in), .Branch_in(br_in),
        .ALUResult_out(alu_out), .WriteData_out(wd_out), .BranchTarget_out(bt_out),
        .WriteReg_out(wr_out), .WBControl_out(wbc_out), .MemWrite_out(mw_out),
        .MemRead_out(mr_out), .Branch_out(br_out), .Zero_out(zero_out), .Stall(stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [5:0] f,
                                            input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        if (op == 2'b00) return a + b;
        if (op == 2'b01) return a - b;
        if (op == 2'b11) return 32'd0;
        case (f)
            F_ADD:   return a + b;
            F_SUB:   return a - b;
            F_AND:   return a & b;
            F_OR:    return a | b;
            F_NOR:   return ~(a | b);
            F_SLT:   return (sa < sb) ? 32'd1 : 32'd0;
            F_MFHI:  return m_hi;
            F_MFLO:  return m_lo;
            default: return 32'd0;
        endcase
    endfunction

    function automatic void ref_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] p;
        logic [63:0] ua, ub;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f)
            F_MULT:  begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
            F_MULTU: begin p = ua * ub; m_hi = p[63:32]; m_lo = p[31:0]; end
            F_DIV: begin
                if (b == 32'd0) begin m_hi = a; m_lo = 32'hFFFF_FFFF; end
                else begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
            end
            default: begin
                if (b == 32'd0) begin m_hi = a; m_lo = 32'hFFFF_FFFF; end
                else begin m_lo = a / b; m_hi = a % b; end
            end
        endcase
    endfunction

    task automatic alu_op(input logic [1:0] op, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] i, input logic [31:0] p,
                          input logic src, input logic dst, input logic [4:0] t,
                          input logic [4:0] d, input logic [4:0] ctl);
        logic [31:0] er;
        @(negedge clk);
        aluop = op; funct = f; rd1 = a; rd2 = b; imm = i; pc4 = p;
        alusrc = src; regdst = dst; rt = t; rd = d;
        {wbc_in, mw_in, mr_in, br_in} = ctl;
        er = ref_alu(op, f, a, src ? i : b);
        #1 chk("stall_alu", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
        chk("alu_result", alu_out, er);
        chk("zero", {31'd0, zero_out}, (er == 32'd0) ? 32'd1 : 32'd0);
        chk("write_reg", {27'd0, wr_out}, {27'd0, dst ? d : t});
        chk("write_data", wd_out, b);
        chk("branch_target", bt_out, p + i * 32'd4);
        chk("ctrl", {27'd0, wbc_out, mw_out, mr_out, br_out}, {27'd0, ctl});
    endtask

    task automatic muldiv(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        int n;
        @(negedge clk);
        aluop = 2'b10; funct = f; rd1 = a; rd2 = b; alusrc = 1'b0;
        {wbc_in, mw_in, mr_in, br_in} = 5'b01000;
        ref_md(f, a, b);
        #1;
        n = 0;
        while (stall && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            chk("bubble_ctrl", {27'd0, wbc_out, mw_out, mr_out, br_out}, 32'd0);
            if (n == 1) begin
                rd1 = $urandom;
                rd2 = $urandom;
            end
        end
        chk("stall_cycles", 32'(n), 32'd33);
        @(posedge clk);
        #1;
        chk("md_ctrl_pass", {27'd0, wbc_out, mw_out, mr_out, br_out}, 32'h0000_0008);
        chk("md_alu_zero", alu_out, 32'd0);
    endtask

    task automatic read_hilo();
        alu_op(2'b10, F_MFHI, $urandom, $urandom, 32'd0, 32'd0, 1'b0, 1'b1, 5'd0, 5'd2, 5'b10000);
        alu_op(2'b10, F_MFLO, $urandom, $urandom, 32'd0, 32'd0, 1'b0, 1'b1, 5'd0, 5'd3, 5'b10000);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0]  alu_f [8] = '{F_ADD, F_SUB, F_AND, F_OR, F_NOR, F_SLT, F_MFHI, 6'h3f};
        logic [5:0]  fr;
        logic [31:0] br;
        int n;

        reset = 1'b1;
        rd1 = 32'd0; rd2 = 32'd0; imm = 32'd0; pc4 = 32'd0; rt = 5'd0; rd = 5'd0;
        funct = 6'd0; aluop = 2'b00; alusrc = 1'b0; regdst = 1'b0;
        wbc_in = 2'b11; mw_in = 1'b1; mr_in = 1'b1; br_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_alu", alu_out, 32'd0);
        chk("rst_ctrl", {27'd0, wbc_out, mw_out, mr_out, br_out}, 32'd0);
        chk("rst_bt", bt_out, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // add 5 + 7
        alu_op(2'b00, 6'd0, 32'd5, 32'd7, 32'd0, 32'h40, 1'b0, 1'b1, 5'd3, 5'd4, 5'b10000);
        chk("add_const", alu_out, 32'd12);
        // beq: 9 - 9, branch target 0x100 + 4*4
        alu_op(2'b01, 6'd0, 32'd9, 32'd9, 32'd4, 32'h100, 1'b0, 1'b0, 5'd9, 5'd1, 5'b00001);
        chk("beq_zero", {31'd0, zero_out}, 32'd1);
        chk("beq_target", bt_out, 32'h110);
        // addi with negative immediate
        alu_op(2'b00, 6'd0, 32'd100, 32'hDEAD_BEEF, 32'hFFFF_FFF0, 32'h8, 1'b1, 1'b0, 5'd7, 5'd8, 5'b10010);
        chk("addi_const", alu_out, 32'd84);

        muldiv(F_MULT, 32'hFFFF_FFFF, 32'd2);
        read_hilo();
        chk("mult_lo_const", alu_out, 32'hFFFF_FFFE);
        muldiv(F_MULTU, 32'hFFFF_FFFF, 32'd2);
        alu_op(2'b10, F_MFHI, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 5'd0, 5'd2, 5'b10000);
        chk("multu_hi_const", alu_out, 32'h1);

        muldiv(F_DIV, 32'hFFFF_FFF9, 32'd2);
        read_hilo();
        chk("div_lo_const", alu_out, 32'hFFFF_FFFD);
        muldiv(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        read_hilo();
        chk("div_ovf_lo_const", alu_out, 32'h8000_0000);
        muldiv(F_DIVU, 32'd7, 32'd0);
        read_hilo();
        chk("divu0_lo_const", alu_out, 32'hFFFF_FFFF);

        // reset asserted during BUSY cycle 10 of a divide
        @(negedge clk);
        aluop = 2'b10; funct = F_DIV; rd1 = 32'd1000; rd2 = 32'd3;
        {wbc_in, mw_in, mr_in, br_in} = 5'b01000;
        #1;
        n = 0;
        while (stall && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("busy_reach10", 32'(n), 32'd10);
        #2;
        reset = 1'b1;
        aluop = 2'b00;
        #1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        chk("midrst_stall", {31'd0, stall}, 32'd0);
        chk("midrst_alu", alu_out, 32'd0);
        chk("midrst_ctrl", {27'd0, wbc_out, mw_out, mr_out, br_out}, 32'd0);
        chk("midrst_zero", {31'd0, zero_out}, 32'd0);
        chk("midrst_wr", {27'd0, wr_out}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        read_hilo();
        chk("midrst_mflo_const", alu_out, 32'd0);

        // back-to-back multiplies
        muldiv(F_MULT, 32'd3, 32'hFFFF_FFFB);
        muldiv(F_MULT, 32'h0001_2345, 32'h0000_6789);
        read_hilo();

        for (int i = 0; i < 24; i++) begin
            alu_op(2'($urandom_range(0, 3)), alu_f[$urandom_range(0, 7)], $urandom, $urandom,
                   $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   5'($urandom), 5'($urandom), 5'($urandom));
        end

        for (int i = 0; i < 8; i++) begin
            fr = F_MULT + 6'($urandom_range(0, 3));
            br = (i == 3) ? 32'd0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300)));
            muldiv(fr, $urandom, br);
            read_hilo();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
